// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes and debounces an asynchronous raw input into a clean level with rise/fall pulses.
// Optional rejected-change counter (glitch_cnt_o) is built when GLITCH_COUNT_EN is defined.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_i,
    input  logic                en_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o
`ifdef GLITCH_COUNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);
    typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
        DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 || GLITCH_W < 1) begin : g_bad_params
        $error("input_debouncer: illegal parameter combination");
    end

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_s;
    logic                   w_last;

    assign w_sync_s = r_sync[SYNC_STAGES-1];
    assign w_last   = (r_cnt == CNT_LAST);
    assign level_o  = r_level;
    assign rise_o   = r_rise;
    assign fall_o   = r_fall;
    assign busy_o   = (r_state == CHK_HI) || (r_state == CHK_LO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end

    // Any exit from a checking state clears the counter, so it never saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: if (en_i && w_sync_s) begin
                    r_state <= CHK_HI;
                    r_cnt   <= CNT_W'(1);
                end
                CHK_HI: if (!en_i || !w_sync_s) begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                end else if (w_last) begin
                    r_state <= STABLE_HI;
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                    r_rise  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                STABLE_HI: if (en_i && !w_sync_s) begin
                    r_state <= CHK_LO;
                    r_cnt   <= CNT_W'(1);
                end
                CHK_LO: if (!en_i || w_sync_s) begin
                    r_state <= STABLE_HI;
                    r_cnt   <= '0;
                end else if (w_last) begin
                    r_state <= STABLE_LO;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_fall  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= STABLE_LO;
            endcase
        end
    end

`ifdef GLITCH_COUNT_EN
    logic [GLITCH_W-1:0] r_glitch;
    logic                w_glitch;

    // Only a reverting sample counts as a glitch; en_i aborts are not rejections.
    assign w_glitch     = en_i && (((r_state == CHK_HI) && !w_sync_s) ||
                                   ((r_state == CHK_LO) && w_sync_s));
    assign glitch_cnt_o = r_glitch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             r_glitch <= '0;
        else if (w_glitch && (r_glitch != '1)) r_glitch <= r_glitch + 1'b1;
    end
`endif

endmodule
